// File: rtl/dual_mult_pipeline_pkg.sv
// Shared constants and types for the dual multiply pipeline.
package dual_mult_pipeline_pkg;

   // Operand and result width.
   localparam int WIDTH = 32;

   // Cycles from operand sample to registered product.
   localparam int MUL_LAT = 2;

   // Offset of the second multiply's operand sample relative to the trigger.
   localparam int SECOND_OFS = 2;

   // Event shift length: covers G .. G+SECOND_OFS+MUL_LAT.
   localparam int EV_LEN = SECOND_OFS + MUL_LAT + 1;

   // Number of multiplier lanes.
   localparam int N_MULT = 2;

   typedef logic [WIDTH-1:0] word_t;

   // Low WIDTH bits of the product; signed and unsigned agree here.
   function automatic word_t mul_lo(input word_t a, input word_t b);
      word_t p;
      p = a * b;
      return p;
   endfunction

endpackage

// File: rtl/dual_mult_pipeline_pipe_mult.sv
// Two-stage registered multiplier with a valid token travelling alongside.
// Stage 1 captures operands only when valid_in is high, so operand X values
// outside the valid window never enter the datapath. Stage 2 loads the
// product only when stage 1 holds a token, so product holds its last value.
module pipe_mult
   import dual_mult_pipeline_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_in,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             valid_out,
   output logic [WIDTH-1:0] product
);

   word_t a_reg;
   word_t b_reg;
   logic  s1_valid_reg;
   word_t product_reg;
   logic  s2_valid_reg;

   // Stage 1: gated operand capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_reg        <= '0;
         b_reg        <= '0;
         s1_valid_reg <= 1'b0;
      end else begin
         s1_valid_reg <= valid_in;
         if (valid_in) begin
            a_reg <= a;
            b_reg <= b;
         end
      end
   end

   // Stage 2: multiply and register the result, holding when idle.
   always_ff @(posedge clk) begin
      if (reset) begin
         product_reg  <= '0;
         s2_valid_reg <= 1'b0;
      end else begin
         s2_valid_reg <= s1_valid_reg;
         if (s1_valid_reg) begin
            product_reg <= mul_lo(a_reg, b_reg);
         end
      end
   end

   assign valid_out = s2_valid_reg;
   assign product   = product_reg;

endmodule

// File: rtl/dual_mult_pipeline.sv
// Trigger-scheduled pair of multiplies. A go_T pulse in cycle G launches
// out0 = l0*r0 (operands sampled at G, result visible from G+2) and
// out1 = l1*r1 (operands sampled at G+2, result visible from G+4).
// Each lane has its own multiplier, so a trigger every cycle is accepted.
module dual_mult_pipeline
   import dual_mult_pipeline_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             go_T,
   input  logic [WIDTH-1:0] l0,
   input  logic [WIDTH-1:0] r0,
   input  logic [WIDTH-1:0] l1,
   input  logic [WIDTH-1:0] r1,
   output logic [WIDTH-1:0] out0,
   output logic [WIDTH-1:0] out1
);

   // ev[k] is high in cycle G+k; ev[0] is the live trigger.
   logic [EV_LEN-1:0] ev;
   logic [EV_LEN-1:1] ev_reg;

   // Per-lane operand, valid and product wiring.
   word_t               op_a   [N_MULT];
   word_t               op_b   [N_MULT];
   word_t               prod   [N_MULT];
   logic  [N_MULT-1:0]  lane_vin;
   logic  [N_MULT-1:0]  lane_vout;

   assign ev[0]        = go_T;
   assign ev[EV_LEN-1:1] = ev_reg;

   // Event shift register; reset drops every in-flight trigger.
   always_ff @(posedge clk) begin
      if (reset) begin
         ev_reg <= '0;
      end else begin
         ev_reg <= ev[EV_LEN-2:0];
      end
   end

   // Lane 0 samples at G, lane 1 samples at G+SECOND_OFS.
   assign lane_vin[0] = ev[0];
   assign lane_vin[1] = ev[SECOND_OFS];
   assign op_a[0]     = l0;
   assign op_b[0]     = r0;
   assign op_a[1]     = l1;
   assign op_b[1]     = r1;

   generate
      for (genvar gi = 0; gi < N_MULT; gi++) begin : g_lane
         pipe_mult u_mult (
            .clk       (clk),
            .reset     (reset),
            .valid_in  (lane_vin[gi]),
            .a         (op_a[gi]),
            .b         (op_b[gi]),
            .valid_out (lane_vout[gi]),
            .product   (prod[gi])
         );
      end
   endgenerate

   // The lane product registers load only on a valid token, so they double
   // as the output hold registers: each output keeps its last result.
   assign out0 = prod[0];
   assign out1 = prod[1];

   // Lane tokens must line up with the event tracker's result cycles.
   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (lane_vout[0] == ev[MUL_LAT]);
         assert (lane_vout[1] == ev[SECOND_OFS + MUL_LAT]);
      end
   end

endmodule

// File: tb/tb_dual_mult_pipeline.sv
// Scoreboard bench for dual_mult_pipeline: stimulus pushes hand-computed
// results with their due cycle; a negedge monitor tracks the held output
// values and compares both outputs every cycle.
module tb_dual_mult_pipeline;

   typedef struct {
      int          due;
      logic [31:0] v;
   } exp_t;

   typedef struct {
      int          due;
      logic [31:0] l;
      logic [31:0] r;
   } bop_t;

   logic        clk;
   logic        reset;
   logic        go_T;
   logic [31:0] l0, r0, l1, r1;
   logic [31:0] out0, out1;

   int   cyc;
   logic rst_q;
   int   checks;
   int   failures;

   exp_t q0[$];
   exp_t q1[$];
   bop_t bq[$];

   logic [31:0] held0, held1;

   dual_mult_pipeline dut (
      .clk   (clk),
      .reset (reset),
      .go_T  (go_T),
      .l0    (l0),
      .r0    (r0),
      .l1    (l1),
      .r1    (r1),
      .out0  (out0),
      .out1  (out1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= reset;
   end

   // Monitor: update the expected held values, then compare.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (cyc > 0) begin
         if (rst_q) begin
            held0 = '0;
            held1 = '0;
         end
         if (q0.size() > 0 && q0[0].due == cyc) begin
            e = q0.pop_front();
            held0 = e.v;
         end
         if (q1.size() > 0 && q1[0].due == cyc) begin
            e = q1.pop_front();
            held1 = e.v;
         end
         checks++;
         if (out0 !== held0) begin
            failures++;
            $display("FAIL out0 cyc=%0d got=%h exp=%h", cyc, out0, held0);
         end
         checks++;
         if (out1 !== held1) begin
            failures++;
            $display("FAIL out1 cyc=%0d got=%h exp=%h", cyc, out1, held1);
         end
      end
   end

   // One cycle of stimulus. A trigger queues its second-multiply operands
   // for G+2 and, when chk is set, its expected results for G+2 / G+4.
   task automatic step(input bit go, input bit chk, input bit tog,
                       input logic [31:0] a0, input logic [31:0] b0,
                       input logic [31:0] a1, input logic [31:0] b1,
                       input logic [31:0] e0, input logic [31:0] e1);
      bop_t bo;
      exp_t ex;
      @(posedge clk);
      #1;
      go_T = go;
      if (go) begin
         l0 = a0;
         r0 = b0;
         bo.due = cyc + 2; bo.l = a1; bo.r = b1;
         bq.push_back(bo);
         if (chk) begin
            ex.due = cyc + 2; ex.v = e0;
            q0.push_back(ex);
            ex.due = cyc + 4; ex.v = e1;
            q1.push_back(ex);
         end
         $display("cyc=%0d go l0=%h r0=%h l1=%h r1=%h exp0=%h exp1=%h chk=%0d",
                  cyc, a0, b0, a1, b1, e0, e1, chk);
      end else if (tog) begin
         l0 = $urandom;
         r0 = $urandom;
      end else begin
         l0 = 'x;
         r0 = 'x;
      end
      if (bq.size() > 0 && bq[0].due == cyc) begin
         bo = bq.pop_front();
         l1 = bo.l;
         r1 = bo.r;
      end else if (tog) begin
         l1 = $urandom;
         r1 = $urandom;
      end else begin
         l1 = 'x;
         r1 = 'x;
      end
   endtask

   task automatic idle(input int n, input bit tog);
      repeat (n) step(1'b0, 1'b0, tog, '0, '0, '0, '0, '0, '0);
   endtask

   task automatic go(input logic [31:0] a0, input logic [31:0] b0,
                     input logic [31:0] a1, input logic [31:0] b1,
                     input logic [31:0] e0, input logic [31:0] e1);
      step(1'b1, 1'b1, 1'b0, a0, b0, a1, b1, e0, e1);
   endtask

   // Reset held for n sampling edges, asserted right after the next edge.
   task automatic do_reset(input int n);
      @(posedge clk);
      #1;
      reset = 1'b1;
      go_T  = 1'b0;
      l0 = 'x; r0 = 'x; l1 = 'x; r1 = 'x;
      bq.delete();
      repeat (n) @(posedge clk);
      #1;
      reset = 1'b0;
      $display("cyc=%0d reset released", cyc);
   endtask

   initial begin
      cyc = 0; rst_q = 1'b0; checks = 0; failures = 0;
      held0 = '0; held1 = '0;
      reset = 1'b1; go_T = 1'b0;
      l0 = 'x; r0 = 'x; l1 = 'x; r1 = 'x;
      repeat (5) @(posedge clk);
      #1;
      reset = 1'b0;

      // No trigger, toggling operands: outputs stay 0.
      idle(10, 1'b1);

      // Basic pair, then hold for 20 cycles.
      go(32'd10, 32'd20, 32'd30, 32'd40, 32'd200, 32'd1200);
      idle(20, 1'b0);

      // Truncation to the low 32 bits.
      go(32'h0001_0000, 32'h0001_0000, 32'hFFFF_FFFF, 32'd2, 32'h0, 32'hFFFF_FFFE);
      idle(6, 1'b0);
      go(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'd3, 32'h1, 32'h8000_0000);
      idle(6, 1'b0);

      // Back-to-back triggers.
      go(32'd3, 32'd4, 32'd7, 32'd8, 32'd12, 32'd56);
      go(32'd5, 32'd6, 32'd9, 32'd10, 32'd30, 32'd90);
      idle(8, 1'b0);

      // Reset at G+1 discards the in-flight pair; outputs clear to 0.
      step(1'b1, 1'b0, 1'b0, 32'd10, 32'd20, 32'd30, 32'd40, '0, '0);
      do_reset(2);
      idle(6, 1'b0);
      go(32'd6, 32'd7, 32'd8, 32'd9, 32'd42, 32'd72);
      idle(6, 1'b0);

      // Trigger at G and G+2, overlapping the first pair's second multiply.
      go(32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd20);
      idle(1, 1'b0);
      go(32'd11, 32'd13, 32'd17, 32'd19, 32'd143, 32'd323);
      idle(8, 1'b0);

      checks++;
      if (q0.size() != 0 || q1.size() != 0) begin
         failures++;
         $display("FAIL drain got=%0d/%0d pending exp=0/0", q0.size(), q1.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dual_mult_pipeline.md
Name: dual_mult_pipeline

Overview:
- Top-level compute block with a single-pulse trigger (go_T).
- One go_T pulse schedules two 32-bit multiplies at fixed offsets from the trigger cycle G:
  - out0 = l0*r0, operands sampled at G.
  - out1 = l1*r1, operands sampled at G+2.
- Each product is produced by a 2-stage pipelined multiplier.
- Fully pipelined: a new go_T is accepted every cycle.

Parameters:
- WIDTH, 32, operand and result width (fixed at 32 for this block; ports sized by it).
- MUL_LAT, 2, multiplier latency in cycles from operand sample to registered result.
- SECOND_OFS, 2, cycle offset of the second multiply's operand sample relative to G.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- go_T  input  1  trigger pulse; high for one cycle marks G. Must be driven 0 explicitly when idle (X is illegal).
- l0  input  32  first-multiply left operand; valid [G, G+2), sampled at G.
- r0  input  32  first-multiply right operand; valid [G, G+1), sampled at G.
- l1  input  32  second-multiply left operand; valid [G+2, G+4), sampled at G+2.
- r1  input  32  second-multiply right operand; valid [G+2, G+3), sampled at G+2.
- out0  output  32  l0*r0 (low 32 bits); valid from G+2.
- out1  output  32  l1*r1 (low 32 bits); valid from G+4.

Behaviour:
- Event tracking:
  - Shift register ev[0..4]; ev[0] = go_T; ev[k] is high in cycle G+k.
  - ev[0] is combinational from go_T; ev[1..4] are registered.
- Multiply A (operands l0, r0):
  - Operands captured into stage-1 registers on the rising edge ending cycle G when ev[0]=1.
  - Product is computed at stage 2 and registered into out0 at the end of G+1.
  - out0 is valid during G+2.
- Multiply B (operands l1, r1):
  - Operands captured at the end of G+2 when ev[2]=1.
  - out1 is valid during G+4.
- Arithmetic: unsigned 32x32 multiply, truncated to the low 32 bits; no overflow flag. Signed and unsigned results are identical in the low 32 bits.
- Output registers load only when their pipeline stage holds a valid token; otherwise they hold the last value.
  - out0 therefore keeps its result until the next go_T's result arrives.
- X-safety: operand X values outside their valid windows must not propagate, because capture is gated by the ev flags.
- Throughput:
  - go_T may be asserted in consecutive cycles; each pulse produces its own pair of results in order.
  - A go_T at G+2 overlapping a pending multiply B uses independent multiplier instances, so there is no structural hazard.
- Reset:
  - reset=1 at a clock edge clears ev[1..4], all pipeline valid bits and operand registers.
  - out0 and out1 are 0 after reset.
  - In-flight operations are discarded (no outputs produced).
  - go_T sampled in a cycle where reset=1 is ignored.
- No handshake/backpressure; the environment must honor the operand validity windows.

Decomposition:
- Shared package: WIDTH, MUL_LAT, SECOND_OFS constants; a word_t typedef for logic [WIDTH-1:0].
- Sub-module pipe_mult, instantiated twice:
  - Inputs: clk, reset, valid_in, a, b.
  - Outputs: valid_out, product (2-stage registered, low-WIDTH bits).
- Top contains the ev shift register, the instances, and the output hold registers.

Test Plan:
1. Reset held 5 cycles, then go_T=1 at cycle 0, l0=10, r0=20; l1=30, r1=40 at cycle 2 (operands X elsewhere) -> out0=200 at cycle 2, out1=1200 at cycle 4; both hold to cycle 20.
2. No go_T after reset, operands toggling -> out0=out1=0 throughout.
3. Overflow: l0=0x0001_0000, r0=0x0001_0000; l1=0xFFFF_FFFF, r1=2 -> out0=0 at G+2, out1=0xFFFF_FFFE at G+4.
4. Back-to-back go_T at cycles 0,1 with (l0,r0)=(3,4),(5,6) and (l1,r1)=(7,8),(9,10) at cycles 2,3 -> out0=12@2, 30@3; out1=56@4, 90@5.
5. Reset asserted at G+1 after go_T (l0=10, r0=20, l1=30, r1=40) -> out0 and out1 stay 0; the next go_T after reset produces correct results.
6. go_T at G and again at G+2 (overlap with multiply B) -> both result pairs correct, each at its own G+2/G+4.
